adsr_envelope: RTL and testbench

Envelope generator for one synth voice, sitting directly downstream of the variable-clock stage. It consumes three variable-rate square waves from three variable-clock instances (attack, decay and release rates, each set by a pot), a sustain pot value and the key gate. It produces a 10-bit envelope amplitude (0–1023) for the output VCA stage. Each rising edge of a phase's rate clock advances the envelope by one step in that phase.

---
 rtl/adsr_envelope.sv | 138 +++++++++++++
 tb/tb_adsr_envelope.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// ADSR envelope generator for one voice: synchronizes the gate and three rate clocks,
// then steps a saturating 10-bit amplitude through attack, decay, sustain and release.
module adsr_envelope #(
    parameter int unsigned STEP = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gate,
    input  logic       attack_clk,
    input  logic       decay_clk,
    input  logic       release_clk,
    input  logic [9:0] sustain_level,
    output logic [9:0] envelope,
    output logic [2:0] state,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } state_e;

    localparam logic [10:0] Step11 = 11'(STEP);
    localparam logic [9:0]  Step10 = 10'(STEP);
    localparam logic [10:0] EnvMax = 11'd1023;

    // Bit order in the conditioning pipeline: {gate, attack, decay, release}
    logic [3:0] meta_q, sync_q, prev_q;
    logic [3:0] rise;
    logic       gate_rise, gate_fall;
    logic       attack_tick, decay_tick, release_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= {gate, attack_clk, decay_clk, release_clk};
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise         = sync_q & ~prev_q;
    assign gate_rise    = rise[3];
    assign gate_fall    = prev_q[3] & ~sync_q[3];
    assign attack_tick  = rise[2];
    assign decay_tick   = rise[1];
    assign release_tick = rise[0];

    state_e      state_q, state_d;
    logic [9:0]  env_q, env_d;
    logic        busy_q, busy_d;
    logic [10:0] attack_sum, decay_floor;

    assign attack_sum  = {1'b0, env_q} + Step11;
    assign decay_floor = {1'b0, sustain_level} + Step11;

    // Gate events are checked before ticks so a coincident tick is dropped.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        unique case (state_q)
            StIdle: begin
                if (gate_rise) state_d = StAttack;
            end
            StAttack: begin
                if (gate_fall) begin
                    state_d = StRelease;
                end else if (attack_tick) begin
                    if (attack_sum >= EnvMax) begin
                        env_d   = 10'd1023;
                        state_d = StDecay;
                    end else begin
                        env_d = attack_sum[9:0];
                    end
                end
            end
            StDecay: begin
                if (gate_fall) begin
                    state_d = StRelease;
                end else if (decay_tick) begin
                    if ({1'b0, env_q} <= decay_floor) begin
                        env_d   = sustain_level;
                        state_d = StSustain;
                    end else begin
                        env_d = env_q - Step10;
                    end
                end
            end
            StSustain: begin
                if (gate_fall) begin
                    state_d = StRelease;
                end else begin
                    env_d = sustain_level;
                end
            end
            StRelease: begin
                if (gate_rise) begin
                    state_d = StAttack;
                end else if (release_tick) begin
                    if (env_q <= Step10) begin
                        env_d   = 10'd0;
                        state_d = StIdle;
                    end else begin
                        env_d = env_q - Step10;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                env_d   = 10'd0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            env_q   <= 10'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            busy_q  <= busy_d;
        end
    end

    assign envelope = env_q;
    assign state    = state_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: scoreboard of expected {envelope, state},
// a full ADSR cycle loop, a vector table and hand-written corner sequences.
module tb_adsr_envelope;

    localparam int unsigned STEP = 8;
    localparam logic [2:0] SI = 3'd0, SA = 3'd1, SD = 3'd2, SS = 3'd3, SR = 3'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       gate = 1'b0;
    logic       attack_clk = 1'b0;
    logic       decay_clk = 1'b0;
    logic       release_clk = 1'b0;
    logic [9:0] sustain_level = 10'd512;
    logic [9:0] envelope;
    logic [2:0] state;
    logic       busy;

    adsr_envelope #(.STEP(STEP)) dut (
        .clk          (clk),
        .reset        (reset),
        .gate         (gate),
        .attack_clk   (attack_clk),
        .decay_clk    (decay_clk),
        .release_clk  (release_clk),
        .sustain_level(sustain_level),
        .envelope     (envelope),
        .state        (state),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] env;
        logic [2:0] st;
        string      name;
    } exp_t;

    typedef enum int {OpGateHi, OpGateLo, OpAtk, OpDec, OpRel, OpSus} op_e;

    typedef struct {
        op_e        op;
        int         count;
        logic [9:0] sus;
        logic [9:0] exp_env;
        logic [2:0] exp_state;
        string      name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    task automatic expect_push(input logic [9:0] env, input logic [2:0] st, input string name);
        exp_t e;
        e.env = env;
        e.st = st;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expected entry for env=%0d state=%0d",
                     envelope, state);
        end else begin
            e = sb.pop_front();
            if (envelope !== e.env || state !== e.st || busy !== (e.st != SI)) begin
                failures++;
                $display("FAIL %s: got env=%0d state=%0d busy=%0d, want env=%0d state=%0d busy=%0d",
                         e.name, envelope, state, busy, e.env, e.st, (e.st != SI));
            end
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic set_rate(input int which, input logic v);
        case (which)
            1: attack_clk = v;
            2: decay_clk = v;
            default: release_clk = v;
        endcase
    endtask

    // One full rate-clock period, 4 clk high then 4 clk low
    task automatic rate_tick(input int which);
        set_rate(which, 1'b1);
        settle();
        set_rate(which, 1'b0);
        settle();
    endtask

    task automatic apply_op(input op_e op, input int count, input logic [9:0] sus);
        case (op)
            OpGateHi: begin gate = 1'b1; settle(); end
            OpGateLo: begin gate = 1'b0; settle(); end
            OpAtk:    repeat (count) rate_tick(1);
            OpDec:    repeat (count) rate_tick(2);
            OpRel:    repeat (count) rate_tick(3);
            default:  begin sustain_level = sus; settle(); end
        endcase
    endtask

    task automatic add_vec(input op_e op, input int count, input logic [9:0] sus,
                           input logic [9:0] env, input logic [2:0] st, input string name);
        vec_t v;
        v.op = op;
        v.count = count;
        v.sus = sus;
        v.exp_env = env;
        v.exp_state = st;
        v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        // Early release, retrigger, sustain edges and tracking, release to idle
        add_vec(OpGateHi, 1,   0,    0,    SA, "t_gate_on");
        add_vec(OpAtk,    50,  0,    400,  SA, "t_attack_400");
        add_vec(OpGateLo, 1,   0,    400,  SR, "t_early_release_hold");
        add_vec(OpAtk,    1,   0,    400,  SR, "t_attack_ignored");
        add_vec(OpRel,    1,   0,    392,  SR, "t_release_392");
        add_vec(OpRel,    24,  0,    200,  SR, "t_release_200");
        add_vec(OpGateHi, 1,   0,    200,  SA, "t_retrigger_200");
        add_vec(OpAtk,    1,   0,    208,  SA, "t_retrigger_step");
        add_vec(OpDec,    1,   0,    208,  SA, "t_decay_ignored");
        add_vec(OpSus,    0,   1023, 208,  SA, "t_sus_1023_set");
        add_vec(OpAtk,    101, 0,    1016, SA, "t_attack_1016");
        add_vec(OpAtk,    1,   0,    1023, SD, "t_attack_clamp");
        add_vec(OpDec,    1,   0,    1023, SS, "t_sus_1023_first");
        add_vec(OpSus,    0,   300,  300,  SS, "t_sus_track_300");
        add_vec(OpGateLo, 1,   0,    300,  SR, "t_release_300");
        add_vec(OpGateHi, 1,   0,    300,  SA, "t_retrigger_300");
        add_vec(OpSus,    0,   0,    300,  SA, "t_sus_0_set");
        add_vec(OpAtk,    91,  0,    1023, SD, "t_attack_to_decay");
        add_vec(OpDec,    127, 0,    7,    SD, "t_decay_7");
        add_vec(OpDec,    1,   0,    0,    SS, "t_decay_floor_0");
        add_vec(OpSus,    0,   300,  300,  SS, "t_sus_track_from_0");
        add_vec(OpGateLo, 1,   0,    300,  SR, "t_release_again");
        add_vec(OpRel,    37,  0,    4,    SR, "t_release_4");
        add_vec(OpRel,    1,   0,    0,    SI, "t_release_clamp_0");

        // Asynchronous reset at time zero
        #1;
        expect_push(10'd0, SI, "reset_state");
        check_out();
        @(negedge clk);
        reset = 1'b0;
        settle();
        expect_push(10'd0, SI, "post_reset_idle");
        check_out();

        // Full cycle
        expect_push(10'd0, SA, "fc_gate_on");
        apply_op(OpGateHi, 1, 0);
        check_out();
        for (int i = 1; i <= 128; i++) begin
            expect_push((i < 128) ? 10'(8 * i) : 10'd1023, (i < 128) ? SA : SD, "fc_attack");
            rate_tick(1);
            check_out();
        end
        for (int i = 1; i <= 64; i++) begin
            expect_push((i < 64) ? 10'(1023 - 8 * i) : 10'd512, (i < 64) ? SD : SS, "fc_decay");
            rate_tick(2);
            check_out();
        end

        // Sustain tracks the pot with one cycle of latency
        sustain_level = 10'd600;
        expect_push(10'd512, SS, "sus_track_before_edge");
        check_out();
        @(posedge clk);
        #1;
        expect_push(10'd600, SS, "sus_track_one_cycle");
        check_out();
        sustain_level = 10'd512;
        settle();

        expect_push(10'd512, SR, "fc_gate_off");
        apply_op(OpGateLo, 1, 0);
        check_out();
        for (int i = 1; i <= 64; i++) begin
            expect_push((i < 64) ? 10'(512 - 8 * i) : 10'd0, (i < 64) ? SR : SI, "fc_release");
            rate_tick(3);
            check_out();
        end

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            expect_push(vecs[i].exp_env, vecs[i].exp_state, vecs[i].name);
            apply_op(vecs[i].op, vecs[i].count, vecs[i].sus);
            check_out();
        end

        // Gate rise and release tick land in the same cycle
        sustain_level = 10'd512;
        gate = 1'b1;
        settle();
        repeat (5) rate_tick(1);
        expect_push(10'd40, SR, "coll_setup");
        apply_op(OpGateLo, 1, 0);
        check_out();
        gate = 1'b1;
        release_clk = 1'b1;
        settle();
        expect_push(10'd40, SA, "coll_gate_wins");
        check_out();
        release_clk = 1'b0;
        settle();
        expect_push(10'd48, SA, "coll_next_attack");
        rate_tick(1);
        check_out();

        // Async reset mid-decay
        repeat (122) rate_tick(1);
        repeat (40) rate_tick(2);
        expect_push(10'd703, SD, "rst_setup_decay");
        check_out();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        expect_push(10'd0, SI, "rst_async_no_edge");
        check_out();
        gate = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        expect_push(10'd0, SI, "rst_stays_idle");
        check_out();

        // Gate already high at reset release starts attack
        @(negedge clk);
        reset = 1'b1;
        gate = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        settle();
        expect_push(10'd0, SA, "rst_gate_high_release");
        check_out();

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, want finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
